// File: rtl/noc_channel_merger.sv
// Merges CH_NUM flit channels onto one output with per-channel FWFT FIFOs
// and a round-robin arbiter that keeps each packet atomic from header to tail.
module noc_channel_merger #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CH_NUM     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst_n,
  input  logic [CH_NUM-1:0]        rx_valid,
  output logic [CH_NUM-1:0]        rx_ready,
  input  logic [CH_NUM*DATA_W-1:0] rx_flit,
  input  logic [CH_NUM-1:0]        rx_is_header,
  input  logic [CH_NUM-1:0]        rx_is_tail,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_flit,
  output logic                     out_is_header,
  output logic                     out_is_tail,
  output logic [CH_W-1:0]          out_channel,
  output logic [15:0]              pkt_cnt,
  output logic [CH_NUM-1:0]        orphan_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t                        r_state;
  logic [CH_W-1:0]               r_grant;
  logic [CH_W-1:0]               r_last_grant;
  logic                          r_rdy_en;
  logic [15:0]                   r_pkt_cnt;
  logic [CH_NUM-1:0]             r_orphan_err;

  logic [CH_NUM-1:0]             w_empty;
  logic [CH_NUM-1:0]             w_full;
  logic [CH_NUM-1:0]             w_push;
  logic [CH_NUM-1:0]             w_pop;
  logic [CH_NUM-1:0][ENT_W-1:0]  w_head;

  logic                          w_hdr_found;
  logic [CH_W-1:0]               w_hdr_ch;
  logic                          w_orph_found;
  logic [CH_W-1:0]               w_orph_ch;
  logic [CH_W-1:0]               w_idx;
  logic                          w_tail_hs;

  // Per-channel FIFO; entry layout is {header, tail, flit}
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    assign w_empty[g]  = (r_wr_ptr == r_rd_ptr);
    assign w_full[g]   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign rx_ready[g] = !w_full[g] && r_rdy_en;
    assign w_push[g]   = rx_valid[g] && rx_ready[g];
    assign w_head[g]   = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
    end

    always_ff @(posedge noc_clk) begin
      if (w_push[g])
        r_mem[r_wr_ptr[PTR_W-1:0]] <= {rx_is_header[g], rx_is_tail[g], rx_flit[g*DATA_W +: DATA_W]};
    end
  end

  // Round-robin scan: first header head wins; an orphan ahead of it is dropped
  always_comb begin
    w_hdr_found  = 1'b0;
    w_hdr_ch     = '0;
    w_orph_found = 1'b0;
    w_orph_ch    = '0;
    w_idx        = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      w_idx = CH_W'((32'(r_last_grant) + k + 32'd1) % CH_NUM);
      if (!w_empty[w_idx] && !w_hdr_found) begin
        if (w_head[w_idx][DATA_W+1]) begin
          w_hdr_found = 1'b1;
          w_hdr_ch    = w_idx;
        end else if (!w_orph_found) begin
          w_orph_found = 1'b1;
          w_orph_ch    = w_idx;
        end
      end
    end
  end

  assign out_valid     = (r_state == ST_LOCK) && !w_empty[r_grant];
  assign out_flit      = (r_state == ST_LOCK) ? w_head[r_grant][DATA_W-1:0] : '0;
  assign out_is_header = (r_state == ST_LOCK) && w_head[r_grant][DATA_W+1];
  assign out_is_tail   = (r_state == ST_LOCK) && w_head[r_grant][DATA_W];
  assign out_channel   = r_grant;
  assign pkt_cnt       = r_pkt_cnt;
  assign orphan_err    = r_orphan_err;
  assign w_tail_hs     = out_valid && out_ready && w_head[r_grant][DATA_W];

  always_comb begin
    w_pop = '0;
    if (r_state == ST_IDLE) begin
      if (w_orph_found) w_pop[w_orph_ch] = 1'b1;
    end else if (out_valid && out_ready) begin
      w_pop[r_grant] = 1'b1;
    end
  end

  // Arbiter: IDLE scans and grants, LOCK forwards the granted packet to its tail
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= CH_W'(CH_NUM - 1);
      r_rdy_en     <= 1'b0;
      r_pkt_cnt    <= '0;
      r_orphan_err <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_orph_found) r_orphan_err[w_orph_ch] <= 1'b1;
          if (w_hdr_found) begin
            r_grant <= w_hdr_ch;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_tail_hs) begin
            r_state      <= ST_IDLE;
            r_last_grant <= r_grant;
            r_pkt_cnt    <= r_pkt_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_channel_merger.sv
// Bench for noc_channel_merger: per-channel packet-stream scoreboard fed by
// directed and randomized traffic.
module tb_noc_channel_merger;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CH_NUM     = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CH_W       = 1;

  logic                     noc_clk = 1'b0;
  logic                     noc_rst_n = 1'b0;
  logic [CH_NUM-1:0]        rx_valid;
  logic [CH_NUM-1:0]        rx_ready;
  logic [CH_NUM*DATA_W-1:0] rx_flit;
  logic [CH_NUM-1:0]        rx_is_header;
  logic [CH_NUM-1:0]        rx_is_tail;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_flit;
  logic                     out_is_header;
  logic                     out_is_tail;
  logic [CH_W-1:0]          out_channel;
  logic [15:0]              pkt_cnt;
  logic [CH_NUM-1:0]        orphan_err;

  noc_channel_merger #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_flit(rx_flit),
    .rx_is_header(rx_is_header), .rx_is_tail(rx_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .out_channel(out_channel), .pkt_cnt(pkt_cnt), .orphan_err(orphan_err)
  );

  always #5 noc_clk = ~noc_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stimulus queues ({hdr, tail, data}) and driver knobs
  logic [33:0] drv_q [CH_NUM][$];
  int          ready_mode = 0;   // 0: always ready, 1: never, 2: random
  bit          rnd_valid  = 1'b0;

  // Scoreboard state
  logic [33:0]       exp_q [CH_NUM][$];
  bit                in_pkt [CH_NUM];
  logic [CH_NUM-1:0] exp_orph = '0;
  int                exp_pkts = 0;
  int                push_cnt [CH_NUM];
  int                hdr_push_cyc [CH_NUM];
  int                cyc = 0;
  int                last_lat = -1;
  int                last_gap = -1;
  int                last_tail_cyc = 0;
  int                ch_log [$];
  bit                out_in_pkt = 1'b0;
  int                cur_ch = 0;
  bit                prev_valid = 1'b0;
  bit                prev_ready = 1'b0;

  initial begin
    bit acc [CH_NUM];
    rx_valid = '0; rx_flit = '0; rx_is_header = '0; rx_is_tail = '0; out_ready = 1'b0;
    forever begin
      @(negedge noc_clk);
      for (int c = 0; c < CH_NUM; c++) acc[c] = rx_valid[c] && rx_ready[c] && noc_rst_n;
      @(posedge noc_clk);
      #1;
      for (int c = 0; c < CH_NUM; c++) begin
        if (acc[c] && drv_q[c].size() > 0) void'(drv_q[c].pop_front());
        if (drv_q[c].size() > 0 && (!rnd_valid || $urandom_range(0, 2) != 0)) begin
          rx_valid[c] = 1'b1;
          {rx_is_header[c], rx_is_tail[c], rx_flit[c*DATA_W +: DATA_W]} = drv_q[c][0];
        end else begin
          rx_valid[c] = 1'b0;
        end
      end
      out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: parse each channel's accepted stream into packets/orphans and
  // check the output against it
  always @(negedge noc_clk) begin
    logic [33:0] e;
    int ch;
    cyc++;
    if (!noc_rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        exp_q[c].delete();
        in_pkt[c] = 1'b0;
        push_cnt[c] = 0;
      end
      exp_orph = '0; exp_pkts = 0; ch_log.delete();
      out_in_pkt = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (rx_valid[c] && rx_ready[c]) begin
          e = {rx_is_header[c], rx_is_tail[c], rx_flit[c*DATA_W +: DATA_W]};
          push_cnt[c]++;
          if (in_pkt[c]) begin
            exp_q[c].push_back(e);
            if (e[32]) begin in_pkt[c] = 1'b0; exp_pkts++; end
          end else if (e[33]) begin
            exp_q[c].push_back(e);
            hdr_push_cyc[c] = cyc;
            if (e[32]) exp_pkts++; else in_pkt[c] = 1'b1;
          end else begin
            exp_orph[c] = 1'b1;
          end
        end
      end
      if (prev_valid && !prev_ready) chk("valid_hold", 64'(out_valid), 64'd1);
      if (out_valid && out_ready) begin
        ch = int'(out_channel);
        if (!out_in_pkt) begin
          chk("pkt_start_hdr", 64'(out_is_header), 64'd1);
          cur_ch = ch; out_in_pkt = 1'b1;
          last_gap = cyc - last_tail_cyc;
          last_lat = cyc - hdr_push_cyc[ch];
          ch_log.push_back(ch);
        end else begin
          chk("pkt_atomic_ch", 64'(ch), 64'(cur_ch));
        end
        chk("flit_expected", 64'(exp_q[ch].size() > 0), 64'd1);
        if (exp_q[ch].size() > 0) begin
          e = exp_q[ch].pop_front();
          chk("flit", 64'({out_is_header, out_is_tail, out_flit}), 64'(e));
        end
        if (out_is_tail) begin out_in_pkt = 1'b0; last_tail_cyc = cyc; end
      end
      prev_valid = out_valid; prev_ready = out_ready;
    end
  end

  // Asserts reset 2ns after the current edge, checks outputs, then releases
  task automatic do_reset();
    #2;
    noc_rst_n = 1'b0;
    for (int c = 0; c < CH_NUM; c++) drv_q[c].delete();
    #1;
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit", 64'(out_flit), 64'd0);
    chk("rst_out_marks", 64'({out_is_header, out_is_tail}), 64'd0);
    chk("rst_out_channel", 64'(out_channel), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_orphan_err", 64'(orphan_err), 64'd0);
    repeat (3) @(negedge noc_clk);
    @(posedge noc_clk);
    #2;
    noc_rst_n = 1'b1;
    @(negedge noc_clk);
    chk("rel_rx_ready_first", 64'(rx_ready), 64'd0);
    @(negedge noc_clk);
    chk("rel_rx_ready_then", 64'(rx_ready), 64'(2'b11));
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_pkt_cnt", 64'(pkt_cnt), 64'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge noc_clk);
      n++;
      done = (drv_q[0].size() == 0) && (drv_q[1].size() == 0) &&
             (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
             !out_valid && (rx_valid == '0);
    end
    chk("drain_in_time", 64'(done), 64'd1);
    repeat (20) @(negedge noc_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int len;
    int wait_n;
    @(posedge noc_clk);
    do_reset();

    // Single 3-flit packet on channel 0
    drv_q[0].push_back({2'b10, 32'hA1});
    drv_q[0].push_back({2'b00, 32'hA2});
    drv_q[0].push_back({2'b01, 32'hA3});
    wait_drain(200);
    chk("p1_latency", 64'(last_lat), 64'd2);
    chk("p1_channel", 64'(ch_log.size() == 1 ? ch_log[0] : -1), 64'd0);
    chk("p1_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Two channels start a packet in the same cycle
    @(posedge noc_clk); do_reset();
    drv_q[0].push_back({2'b10, 32'hB1}); drv_q[0].push_back({2'b01, 32'hB2});
    drv_q[1].push_back({2'b10, 32'hC1}); drv_q[1].push_back({2'b01, 32'hC2});
    wait_drain(200);
    chk("p2_count", 64'(ch_log.size()), 64'd2);
    if (ch_log.size() == 2) begin
      chk("p2_first_ch", 64'(ch_log[0]), 64'd0);
      chk("p2_second_ch", 64'(ch_log[1]), 64'd1);
    end
    chk("p2_idle_gap", 64'(last_gap), 64'd2);
    chk("p2_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Fill channel 1 with the output stalled
    @(posedge noc_clk); do_reset();
    ready_mode = 1;
    for (int j = 0; j < 6; j++) drv_q[1].push_back({j == 0, j == 5, 32'hD0 + 32'(j)});
    repeat (12) @(negedge noc_clk);
    chk("full_push_cnt", 64'(push_cnt[1]), 64'(FIFO_DEPTH));
    chk("full_rx_ready", 64'(rx_ready[1]), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_out_flit", 64'(out_flit), 64'hD0);
    chk("full_out_channel", 64'(out_channel), 64'd1);
    ready_mode = 0;
    wait_drain(200);
    chk("full_all_pushed", 64'(push_cnt[1]), 64'd6);
    chk("full_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Orphan flit ahead of a normal packet
    @(posedge noc_clk); do_reset();
    drv_q[0].push_back({2'b00, 32'h55});
    drv_q[0].push_back({2'b10, 32'hE1});
    drv_q[0].push_back({2'b01, 32'hE2});
    wait_drain(200);
    chk("orph_flag", 64'(orphan_err), 64'(2'b01));
    chk("orph_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("orph_pkts_out", 64'(ch_log.size()), 64'd1);
    repeat (10) @(negedge noc_clk);
    chk("orph_sticky", 64'(orphan_err), 64'(2'b01));

    // Reset in the middle of a 4-flit packet
    @(posedge noc_clk); do_reset();
    for (int j = 0; j < 4; j++) drv_q[0].push_back({j == 0, j == 3, 32'hF0 + 32'(j)});
    wait_n = 0;
    while (push_cnt[0] < 2 && wait_n < 100) begin @(posedge noc_clk); wait_n++; end
    chk("mid_reset_reached", 64'(push_cnt[0] == 2), 64'd1);
    do_reset();
    drv_q[0].push_back({2'b10, 32'h71});
    drv_q[0].push_back({2'b00, 32'h72});
    drv_q[0].push_back({2'b01, 32'h73});
    wait_drain(200);
    chk("mid_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Randomized traffic with random valid and ready
    @(posedge noc_clk); do_reset();
    for (int it = 0; it < 4; it++) begin
      ready_mode = 2; rnd_valid = 1'b1;
      for (int c = 0; c < CH_NUM; c++) begin
        for (int p = 0; p < 6; p++) begin
          if ($urandom_range(0, 3) == 0) drv_q[c].push_back({1'b0, 1'($urandom), 32'($urandom)});
          len = int'($urandom_range(1, 5));
          for (int j = 0; j < len; j++) drv_q[c].push_back({j == 0, j == len - 1, 32'($urandom)});
        end
      end
      wait_drain(4000);
      chk("rnd_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkts)));
      chk("rnd_orphan_err", 64'(orphan_err), 64'(exp_orph));
    end
    ready_mode = 0; rnd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
